// File: rtl/cdi_video_pkg.sv
// cdi_video_pkg: raster geometry and video mode type shared by the timing generator and the mixer.
package cdi_video_pkg;
    localparam int CLK_DIV       = 4;
    localparam int H_ACTIVE      = 768;
    localparam int H_TOTAL_NTSC  = 952;
    localparam int H_TOTAL_PAL   = 960;
    localparam int H_SYNC_START  = 800;
    localparam int H_SYNC_LEN    = 70;
    localparam int V_ACTIVE_NTSC = 240;
    localparam int V_ACTIVE_PAL  = 280;
    localparam int V_SYNC_NTSC   = 244;
    localparam int V_SYNC_PAL    = 290;
    localparam int V_SYNC_LEN    = 3;
    localparam int V_TOTAL_NTSC  = 262;
    localparam int V_TOTAL_PAL   = 312;
    typedef enum logic {MODE_NTSC = 1'b0, MODE_PAL = 1'b1} video_mode_e;
endpackage

// File: rtl/cdi_pixel_ce.sv
// cdi_pixel_ce: clock divider producing the registered one-clk pixel enable.
module cdi_pixel_ce #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic adv_o,
    output logic ce_pix_o
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div_q;
    // adv_o marks the edge on which ce_pix and the counters all update together
    assign adv_o = div_q == DW'(CLK_DIV - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            ce_pix_o <= 1'b0;
        end else begin
            div_q    <= adv_o ? '0 : div_q + 1'b1;
            ce_pix_o <= adv_o;
        end
    end
endmodule

// File: rtl/cdi_video_timing.sv
// cdi_video_timing: NTSC/PAL raster generator with beam counters, blank, sync and frame-aligned mode switch.
module cdi_video_timing
    import cdi_video_pkg::*;
#(
    parameter int G_CLK_DIV       = CLK_DIV,
    parameter int G_H_ACTIVE      = H_ACTIVE,
    parameter int G_H_TOTAL_NTSC  = H_TOTAL_NTSC,
    parameter int G_H_TOTAL_PAL   = H_TOTAL_PAL,
    parameter int G_H_SYNC_START  = H_SYNC_START,
    parameter int G_H_SYNC_LEN    = H_SYNC_LEN,
    parameter int G_V_ACTIVE_NTSC = V_ACTIVE_NTSC,
    parameter int G_V_ACTIVE_PAL  = V_ACTIVE_PAL,
    parameter int G_V_SYNC_NTSC   = V_SYNC_NTSC,
    parameter int G_V_SYNC_PAL    = V_SYNC_PAL,
    parameter int G_V_SYNC_LEN    = V_SYNC_LEN,
    parameter int G_V_TOTAL_NTSC  = V_TOTAL_NTSC,
    parameter int G_V_TOTAL_PAL   = V_TOTAL_PAL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    output logic       ce_pix,
    output logic [9:0] hcnt,
    output logic [8:0] vcnt,
    output logic       HBlank,
    output logic       VBlank,
    output logic       HSync,
    output logic       VSync,
    output logic       new_line,
    output logic       new_frame,
    output logic       pal_active
);
    localparam logic [9:0] HA    = 10'(G_H_ACTIVE);
    localparam logic [9:0] HTN_L = 10'(G_H_TOTAL_NTSC - 1);
    localparam logic [9:0] HTP_L = 10'(G_H_TOTAL_PAL - 1);
    localparam logic [9:0] HSS   = 10'(G_H_SYNC_START);
    localparam logic [9:0] HSE   = 10'(G_H_SYNC_START + G_H_SYNC_LEN);
    localparam logic [8:0] VAN   = 9'(G_V_ACTIVE_NTSC);
    localparam logic [8:0] VAP   = 9'(G_V_ACTIVE_PAL);
    localparam logic [8:0] VSN   = 9'(G_V_SYNC_NTSC);
    localparam logic [8:0] VSP   = 9'(G_V_SYNC_PAL);
    localparam logic [8:0] VTN_L = 9'(G_V_TOTAL_NTSC - 1);
    localparam logic [8:0] VTP_L = 9'(G_V_TOTAL_PAL - 1);
    localparam logic [8:0] VSL   = 9'(G_V_SYNC_LEN);

    logic        adv, h_wrap, v_wrap;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [8:0]  vcnt_q, vcnt_d, va, vs0;
    video_mode_e mode_q, mode_d;
    logic        hb_q, vb_q, hs_q, vs_q, nl_q, nf_q;

    cdi_pixel_ce #(.CLK_DIV(G_CLK_DIV)) u_ce (
        .clk     (clk),
        .reset   (reset),
        .adv_o   (adv),
        .ce_pix_o(ce_pix)
    );

    // Blank/sync decode from the next-state counters so they register in step with hcnt/vcnt
    always_comb begin
        h_wrap = hcnt_q == ((mode_q == MODE_PAL) ? HTP_L : HTN_L);
        v_wrap = vcnt_q == ((mode_q == MODE_PAL) ? VTP_L : VTN_L);
        hcnt_d = h_wrap ? '0 : hcnt_q + 10'd1;
        vcnt_d = !h_wrap ? vcnt_q : (v_wrap ? '0 : vcnt_q + 9'd1);
        mode_d = (h_wrap && v_wrap) ? video_mode_e'(pal) : mode_q;
        va     = (mode_d == MODE_PAL) ? VAP : VAN;
        vs0    = (mode_d == MODE_PAL) ? VSP : VSN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            mode_q <= video_mode_e'(pal);
            hb_q   <= 1'b0;
            vb_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            nl_q   <= 1'b0;
            nf_q   <= 1'b0;
        end else if (adv) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            mode_q <= mode_d;
            hb_q   <= hcnt_d >= HA;
            vb_q   <= vcnt_d >= va;
            hs_q   <= (hcnt_d >= HSS) && (hcnt_d < HSE);
            vs_q   <= (vcnt_d >= vs0) && (vcnt_d < vs0 + VSL);
            nl_q   <= h_wrap;
            nf_q   <= h_wrap && v_wrap;
        end else begin
            nl_q   <= 1'b0;
            nf_q   <= 1'b0;
        end
    end

    assign hcnt       = hcnt_q;
    assign vcnt       = vcnt_q;
    assign HBlank     = hb_q;
    assign VBlank     = vb_q;
    assign HSync      = hs_q;
    assign VSync      = vs_q;
    assign new_line   = nl_q;
    assign new_frame  = nf_q;
    assign pal_active = mode_q == MODE_PAL;
endmodule

// File: tb/tb_cdi_video_timing.sv
// tb_cdi_video_timing: scoreboard bench for a shrunken raster and a full-size raster sharing clk/reset/pal.
module tb_cdi_video_timing;
    typedef struct packed {
        logic [9:0] h;
        logic [8:0] v;
        logic hb, vb, hs, vs, nl, nf, pa;
    } obs_t;

    localparam int D = 4;
    localparam int HA[2]  = '{16, 768};
    localparam int HTN[2] = '{22, 952};
    localparam int HTP[2] = '{24, 960};
    localparam int HSS[2] = '{18, 800};
    localparam int HSL[2] = '{3, 70};
    localparam int VAN[2] = '{8, 240};
    localparam int VAP[2] = '{10, 280};
    localparam int VSN[2] = '{9, 244};
    localparam int VSP[2] = '{11, 290};
    localparam int VSL[2] = '{2, 3};
    localparam int VTN[2] = '{11, 262};
    localparam int VTP[2] = '{14, 312};

    logic clk = 1'b0, reset = 1'b1, pal = 1'b0;
    logic ce0, ce1;
    logic [9:0] h0, h1;
    logic [8:0] v0, v1;
    logic hb0, vb0, hs0, vs0, nl0, nf0, pa0;
    logic hb1, vb1, hs1, vs1, nl1, nf1, pa1;
    obs_t o0, o1;

    cdi_video_timing #(
        .G_CLK_DIV(D), .G_H_ACTIVE(16), .G_H_TOTAL_NTSC(22), .G_H_TOTAL_PAL(24),
        .G_H_SYNC_START(18), .G_H_SYNC_LEN(3), .G_V_ACTIVE_NTSC(8), .G_V_ACTIVE_PAL(10),
        .G_V_SYNC_NTSC(9), .G_V_SYNC_PAL(11), .G_V_SYNC_LEN(2), .G_V_TOTAL_NTSC(11),
        .G_V_TOTAL_PAL(14)
    ) dut (
        .clk(clk), .reset(reset), .pal(pal), .ce_pix(ce0), .hcnt(h0), .vcnt(v0),
        .HBlank(hb0), .VBlank(vb0), .HSync(hs0), .VSync(vs0), .new_line(nl0),
        .new_frame(nf0), .pal_active(pa0)
    );

    cdi_video_timing dut_full (
        .clk(clk), .reset(reset), .pal(pal), .ce_pix(ce1), .hcnt(h1), .vcnt(v1),
        .HBlank(hb1), .VBlank(vb1), .HSync(hs1), .VSync(vs1), .new_line(nl1),
        .new_frame(nf1), .pal_active(pa1)
    );

    assign o0 = {h0, v0, hb0, vb0, hs0, vs0, nl0, nf0, pa0};
    assign o1 = {h1, v1, hb1, vb1, hs1, vs1, nl1, nf1, pa1};

    always #5 clk = ~clk;

    // Reference model: beam position since release, raster rules applied with plain arithmetic
    int   mk[2], mh[2], mv[2];
    bit   mm[2], exp_ce[2], exp_rst[2];
    obs_t q0[$], q1[$];
    int   nchk = 0, npass = 0, timeouts = 0;
    bit   done = 1'b0;

    function automatic obs_t expect_at(int g, int h, int v, bit m, bit nl, bit nf);
        obs_t e;
        int vsy;
        vsy  = m ? VSP[g] : VSN[g];
        e.h  = 10'(h);
        e.v  = 9'(v);
        e.hb = h >= HA[g];
        e.vb = v >= (m ? VAP[g] : VAN[g]);
        e.hs = (h >= HSS[g]) && (h < HSS[g] + HSL[g]);
        e.vs = (v >= vsy) && (v < vsy + VSL[g]);
        e.nl = nl;
        e.nf = nf;
        e.pa = m;
        return e;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                mk[g] = 0; mh[g] = 0; mv[g] = 0; mm[g] = pal;
                exp_rst[g] = 1'b1; exp_ce[g] = 1'b0;
            end else begin
                exp_rst[g] = 1'b0;
                exp_ce[g]  = (mk[g] % D) == D - 1;
                mk[g]++;
                if (exp_ce[g]) begin
                    bit nl, nf;
                    nl = 1'b0; nf = 1'b0;
                    mh[g]++;
                    if (mh[g] == (mm[g] ? HTP[g] : HTN[g])) begin
                        mh[g] = 0; nl = 1'b1; mv[g]++;
                        if (mv[g] == (mm[g] ? VTP[g] : VTN[g])) begin
                            mv[g] = 0; nf = 1'b1; mm[g] = pal;
                        end
                    end
                    if (g == 0) q0.push_back(expect_at(g, mh[g], mv[g], mm[g], nl, nf));
                    else        q1.push_back(expect_at(g, mh[g], mv[g], mm[g], nl, nf));
                end
            end
        end
    end

    task automatic check(input string nm, input int g, input logic [25:0] a, input logic [25:0] e);
        nchk++;
        if (a === e) npass++;
        else $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, g, $time, a, e);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            obs_t a, e;
            logic ce;
            a  = (g == 0) ? o0 : o1;
            ce = (g == 0) ? ce0 : ce1;
            check("ce_pix", g, {25'd0, ce}, {25'd0, exp_ce[g]});
            if (exp_rst[g]) check("reset_state", g, a, expect_at(g, 0, 0, mm[g], 1'b0, 1'b0));
            else if (g == 0 && q0.size() != 0) begin
                e = q0.pop_front();
                if (ce) check("pixel", g, a, e);
            end else if (g == 1 && q1.size() != 0) begin
                e = q1.pop_front();
                if (ce) check("pixel", g, a, e);
            end else check("pulse_width", g, {24'd0, a.nl, a.nf}, 26'd0);
        end
        if (done) begin
            check("wait_bound", 0, 26'(timeouts), 26'd0);
            $display("%0d/%0d checks passed", npass, nchk);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit tog);
        for (int i = 0; i < n; i++) begin
            tick();
            if (tog && $urandom_range(0, 399) == 0) pal = ~pal;
        end
    endtask

    initial begin
        reset = 1'b1; pal = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        run(8000, 1'b0);
        pal = 1'b1;
        run(9000, 1'b0);
        for (int r = 0; r < 4; r++) begin
            int i;
            pal = 1'($urandom);
            run($urandom_range(2000, 6000), 1'b1);
            for (i = 0; i < 8000 && h1 != 10'd500; i++) @(negedge clk);
            if (i == 8000) timeouts++;
            tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        pal = 1'($urandom);
        run(4000, 1'b1);
        done = 1'b1;
    end
endmodule
